// File: rtl/game_pkg.sv
// Screen geometry, parked-slot coordinates and the bullet-pool FSM encoding
// shared by the game-side blocks that feed the VGA controller.
package game_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PARK_X      = SCREEN_W;
    localparam int PARK_Y      = SCREEN_H;
    localparam int NUM_BULLETS = 5;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        SPAWN
    } pool_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: the input is captured once and compared,
// giving a one-cycle pulse the cycle after the input rises.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_in;
            r_rise <= i_in & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/bullet_pool.sv
// Five-slot player bullet manager: a per-frame move/retire sweep over the slots
// followed by a cooldown-gated spawn above the player sprite.
module bullet_pool #(
    parameter int NUM_BULLETS     = game_pkg::NUM_BULLETS,
    parameter int BULLET_SPEED    = 4,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int SPRITE_W        = 50,
    parameter int BULLET_H        = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frameTick,
    input  logic                   fire,
    input  logic [9:0]             playerX,
    input  logic [8:0]             playerY,
    input  logic [NUM_BULLETS-1:0] hitMask,
    output logic [9:0]             bullet1X,
    output logic [9:0]             bullet2X,
    output logic [9:0]             bullet3X,
    output logic [9:0]             bullet4X,
    output logic [9:0]             bullet5X,
    output logic [8:0]             bullet1Y,
    output logic [8:0]             bullet2Y,
    output logic [8:0]             bullet3Y,
    output logic [8:0]             bullet4Y,
    output logic [8:0]             bullet5Y,
    output logic [NUM_BULLETS-1:0] activeMask,
    output logic                   busy
);
    import game_pkg::*;

    localparam int         IDX_W  = $clog2(NUM_BULLETS);
    localparam int         CD_W   = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [9:0] PARK_XV = 10'(PARK_X);
    localparam logic [8:0] PARK_YV = 9'(PARK_Y);

    logic w_tick_rise;
    logic w_fire_rise;

    rise_detect u_tick_rise (
        .clk    (clk),
        .reset  (reset),
        .i_in   (frameTick),
        .o_rise (w_tick_rise)
    );

    rise_detect u_fire_rise (
        .clk    (clk),
        .reset  (reset),
        .i_in   (fire),
        .o_rise (w_fire_rise)
    );

    pool_state_t            r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CD_W-1:0]        r_cooldown;
    logic                   r_fire_pend;
    logic                   r_busy;
    logic [9:0]             r_x [NUM_BULLETS];
    logic [8:0]             r_y [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] r_active;

    logic [10:0]      w_sum_x;
    logic [9:0]       w_spawn_x;
    logic [8:0]       w_spawn_y;
    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;

    // Sum is one bit wider so a right-edge player cannot wrap the bullet to the left.
    assign w_sum_x   = {1'b0, playerX} + 11'(SPRITE_W / 2);
    assign w_spawn_x = (w_sum_x > 11'(SCREEN_W - 1)) ? 10'(SCREEN_W - 1) : w_sum_x[9:0];
    assign w_spawn_y = (playerY < 9'(BULLET_H)) ? 9'd0 : playerY - 9'(BULLET_H);

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_cooldown  <= '0;
            r_fire_pend <= 1'b0;
            r_busy      <= 1'b0;
            r_active    <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_x[i] <= PARK_XV;
                r_y[i] <= PARK_YV;
            end
        end else begin
            if (w_fire_rise) r_fire_pend <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_tick_rise) begin
                        r_state <= UPDATE;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        if (r_cooldown != '0) r_cooldown <= r_cooldown - 1'b1;
                    end
                end
                UPDATE: begin
                    if (r_active[r_idx]) begin
                        if (r_y[r_idx] < 9'(BULLET_SPEED)) begin
                            r_active[r_idx] <= 1'b0;
                            r_x[r_idx]      <= PARK_XV;
                            r_y[r_idx]      <= PARK_YV;
                        end else begin
                            r_y[r_idx] <= r_y[r_idx] - 9'(BULLET_SPEED);
                        end
                    end
                    if (r_idx == IDX_W'(NUM_BULLETS - 1)) r_state <= SPAWN;
                    else                                  r_idx   <= r_idx + 1'b1;
                end
                SPAWN: begin
                    r_fire_pend <= 1'b0;
                    if (r_fire_pend && r_cooldown == '0 && w_free_found) begin
                        r_active[w_free_idx] <= 1'b1;
                        r_x[w_free_idx]      <= w_spawn_x;
                        r_y[w_free_idx]      <= w_spawn_y;
                        r_cooldown           <= CD_W'(COOLDOWN_FRAMES);
                    end
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase

            // Hits are applied last so they override a same-cycle move of that slot.
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (hitMask[i] && r_active[i]) begin
                    r_active[i] <= 1'b0;
                    r_x[i]      <= PARK_XV;
                    r_y[i]      <= PARK_YV;
                end
            end
        end
    end

    assign bullet1X   = r_x[0];
    assign bullet2X   = r_x[1];
    assign bullet3X   = r_x[2];
    assign bullet4X   = r_x[3];
    assign bullet5X   = r_x[4];
    assign bullet1Y   = r_y[0];
    assign bullet2Y   = r_y[1];
    assign bullet3Y   = r_y[2];
    assign bullet4Y   = r_y[3];
    assign bullet5Y   = r_y[4];
    assign activeMask = r_active;
    assign busy       = r_busy;

endmodule
